// File: rtl/cnn_pkg.sv
// Shared constants and types for the conv datapath write-back path.
package cnn_pkg;

    localparam int unsigned MAC_BEAT_BYTES = 18;
    localparam int unsigned DDR_WORD_BYTES = 32;

    localparam int unsigned DEF_IN_WIDTH   = MAC_BEAT_BYTES * 8;
    localparam int unsigned DEF_OUT_WIDTH  = DDR_WORD_BYTES * 8;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_BUF_BYTES  = MAC_BEAT_BYTES + DDR_WORD_BYTES;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/ddr_pack_outreg.sv
// Output holding register for the DDR write word: loads only when free and holds
// data/address/last stable while the sink stalls.
module ddr_pack_outreg #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_free,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;

    assign o_free = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (o_free) begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
                r_addr <= i_addr;
                r_last <= i_last;
            end else begin
                r_last <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_last  = r_last;

endmodule

// File: rtl/ddr_write_packer.sv
// Repacks 18-byte MAC result beats into byte-contiguous 32-byte DDR write words,
// little-endian, with per-word byte address and tile-end flush of the residual.
module ddr_write_packer
    import cnn_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned BUF_BYTES  = DEF_BUF_BYTES
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  state_rst,
    input  logic [ADDR_WIDTH-1:0] wr_base_addr_in,
    input  logic [IN_WIDTH-1:0]   MAC_data_in,
    input  logic                  MAC_data_valid_in,
    input  logic                  MAC_last_in,
    output logic                  MAC_ready_out,
    output logic [OUT_WIDTH-1:0]  DDR_data_out,
    output logic [ADDR_WIDTH-1:0] DDR_addr_out,
    output logic                  DDR_valid_out,
    output logic                  DDR_last_out,
    input  logic                  DDR_ready_in
);

    localparam int unsigned IN_BYTES  = IN_WIDTH / 8;
    localparam int unsigned OUT_BYTES = OUT_WIDTH / 8;
    localparam int unsigned CNT_W     = $clog2(BUF_BYTES + 1);
    // Largest fill that still has room for a full beat when no word can leave.
    localparam int unsigned READY_MAX = BUF_BYTES - IN_BYTES;

    byte_t                 r_buf [BUF_BYTES];
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_flush;
    logic [ADDR_WIDTH-1:0] r_addr;

    byte_t                 w_buf_d [BUF_BYTES];
    logic [CNT_W-1:0]      w_cnt_d;
    logic [31:0]           w_cnt;
    logic [31:0]           w_rem;
    logic                  w_ready;
    logic                  w_push;
    logic                  w_free;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_load;
    logic                  w_last;
    logic [OUT_WIDTH-1:0]  w_word;

    assign w_cnt   = 32'(r_cnt);
    assign w_ready = rstn && (w_cnt <= READY_MAX) && !r_flush;
    assign w_push  = MAC_data_valid_in && w_ready;
    assign w_pop   = w_free && (w_cnt >= OUT_BYTES);
    assign w_flush = w_free && r_flush && (w_cnt != 32'd0) && (w_cnt < OUT_BYTES);
    assign w_load  = w_pop || w_flush;
    assign w_last  = w_flush || (w_pop && r_flush && (w_cnt == OUT_BYTES));

    assign MAC_ready_out = w_ready;

    // Bytes above the fill level are padded with zero on a partial flush.
    always_comb begin
        w_word = '0;
        for (int unsigned j = 0; j < OUT_BYTES; j++) begin
            if (j < w_cnt) begin
                w_word[j*8 +: 8] = r_buf[j];
            end
        end
    end

    always_comb begin
        w_buf_d = r_buf;
        w_rem   = w_cnt;
        if (w_pop) begin
            w_rem = w_cnt - OUT_BYTES;
            for (int unsigned j = 0; j < BUF_BYTES - OUT_BYTES; j++) begin
                w_buf_d[j] = r_buf[j + OUT_BYTES];
            end
            for (int unsigned j = BUF_BYTES - OUT_BYTES; j < BUF_BYTES; j++) begin
                w_buf_d[j] = '0;
            end
        end else if (w_flush) begin
            w_rem = 32'd0;
        end
        if (w_push) begin
            for (int unsigned j = 0; j < BUF_BYTES; j++) begin
                if ((j >= w_rem) && (j < w_rem + IN_BYTES)) begin
                    w_buf_d[j] = MAC_data_in[(j - w_rem)*8 +: 8];
                end
            end
        end
        w_cnt_d = CNT_W'(w_rem + (w_push ? IN_BYTES : 32'd0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned j = 0; j < BUF_BYTES; j++) begin
                r_buf[j] <= '0;
            end
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_addr  <= '0;
        end else if (state_rst) begin
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_addr  <= wr_base_addr_in;
        end else begin
            r_buf <= w_buf_d;
            r_cnt <= w_cnt_d;
            if (w_push && MAC_last_in) begin
                r_flush <= 1'b1;
            end else if (w_last || (r_flush && w_cnt == 32'd0)) begin
                r_flush <= 1'b0;
            end
            if (w_load) begin
                r_addr <= r_addr + ADDR_WIDTH'(OUT_BYTES);
            end
        end
    end

    ddr_pack_outreg #(
        .DATA_WIDTH (OUT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_outreg (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (state_rst),
        .i_load  (w_load && !state_rst),
        .i_data  (w_word),
        .i_addr  (r_addr),
        .i_last  (w_last),
        .i_ready (DDR_ready_in),
        .o_free  (w_free),
        .o_valid (DDR_valid_out),
        .o_data  (DDR_data_out),
        .o_addr  (DDR_addr_out),
        .o_last  (DDR_last_out)
    );

endmodule

// File: tb/tb_ddr_write_packer.sv
// Randomized bench for ddr_write_packer against a byte-queue reference model.
module tb_ddr_write_packer;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         state_rst = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [143:0] mac_data = '0;
    logic         mac_valid = 1'b0;
    logic         mac_last = 1'b0;
    logic         ddr_ready = 1'b0;
    logic         MAC_ready_out;
    logic [255:0] DDR_data_out;
    logic [31:0]  DDR_addr_out;
    logic         DDR_valid_out;
    logic         DDR_last_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_write_packer dut (
        .clk               (clk),
        .rstn              (rstn),
        .state_rst         (state_rst),
        .wr_base_addr_in   (base_addr),
        .MAC_data_in       (mac_data),
        .MAC_data_valid_in (mac_valid),
        .MAC_last_in       (mac_last),
        .MAC_ready_out     (MAC_ready_out),
        .DDR_data_out      (DDR_data_out),
        .DDR_addr_out      (DDR_addr_out),
        .DDR_valid_out     (DDR_valid_out),
        .DDR_last_out      (DDR_last_out),
        .DDR_ready_in      (ddr_ready)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: a byte FIFO plus one output word ----------------
    logic [7:0]   m_q[$];
    logic         m_flush = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_last  = 1'b0;
    logic [255:0] m_data  = '0;
    logic [31:0]  m_addr  = '0;
    logic [31:0]  m_areg  = '0;
    bit           mf_free;
    bit           mf_push;
    int           mf_n;

    function automatic bit m_ready();
        return rstn && (m_q.size() <= 32) && !m_flush;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_flush = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_data  = '0;
            m_addr  = '0;
            m_areg  = '0;
        end else begin
            mf_push = mac_valid && m_ready();
            mf_free = !m_valid || ddr_ready;
            if (state_rst) begin
                m_q.delete();
                m_flush = 1'b0;
                m_valid = 1'b0;
                m_last  = 1'b0;
                m_areg  = base_addr;
            end else begin
                if (mf_free) begin
                    mf_n = m_q.size();
                    if (mf_n >= 32 || (m_flush && mf_n > 0)) begin
                        m_data = '0;
                        for (int j = 0; j < 32 && j < mf_n; j++) m_data[j*8 +: 8] = m_q.pop_front();
                        m_valid = 1'b1;
                        m_addr  = m_areg;
                        m_areg  = m_areg + 32;
                        m_last  = m_flush && (mf_n <= 32);
                        if (m_last) m_flush = 1'b0;
                    end else begin
                        m_valid = 1'b0;
                        m_last  = 1'b0;
                    end
                end
                if (mf_push) begin
                    for (int b = 0; b < 18; b++) m_q.push_back(mac_data[b*8 +: 8]);
                    if (mac_last) m_flush = 1'b1;
                end
            end
        end
    end

    // Words handed to the sink
    logic [255:0] cap_d[$];
    logic [31:0]  cap_a[$];
    logic         cap_l[$];
    logic [7:0]   sent[$];

    always @(posedge clk) begin
        if (rstn && DDR_valid_out && ddr_ready) begin
            cap_d.push_back(DDR_data_out);
            cap_a.push_back(DDR_addr_out);
            cap_l.push_back(DDR_last_out);
        end
    end

    task automatic tick();
        @(negedge clk);
        check_eq("ready", MAC_ready_out, m_ready());
        check_eq("valid", DDR_valid_out, m_valid);
        check_eq("last", DDR_last_out, m_last);
        check_eq("addr", DDR_addr_out, m_addr);
        check_eq("data", DDR_data_out, m_data);
    endtask

    logic [7:0] seq_cnt = '0;

    task automatic gen_beat(input bit rnd);
        for (int b = 0; b < 18; b++)
            mac_data[b*8 +: 8] = rnd ? 8'($urandom) : 8'(seq_cnt + 8'(b));
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_a.delete(); cap_l.delete(); sent.delete();
        seq_cnt = '0;
    endtask

    // Drive one beat slot; returns whether the model accepted it.
    task automatic drive_slot(input bit rnd, input int valid_pct, input bit last, output bit acc);
        mac_valid = ($urandom_range(99) < valid_pct);
        gen_beat(rnd);
        mac_last = last;
        acc = mac_valid && m_ready();
        if (acc) begin
            for (int b = 0; b < 18; b++) sent.push_back(mac_data[b*8 +: 8]);
            seq_cnt = seq_cnt + 8'd18;
        end
        tick();
    endtask

    task automatic send_tile(input int nb, input bit do_rst, input logic [31:0] b_addr,
                             input bit rnd, input int ready_pct, input int valid_pct,
                             input int stall_at);
        int i = 0;
        int budget = 0;
        bit acc;
        bit snap_v;
        logic [255:0] snap_d;
        logic [31:0]  snap_a;
        int nw;
        logic [255:0] exp_w;
        if (do_rst) begin
            state_rst = 1'b1; base_addr = b_addr; mac_valid = 1'b0;
            tick();
            state_rst = 1'b0;
        end
        clear_caps();
        while (i < nb && budget < 3000) begin
            if (i == stall_at) begin
                snap_v = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    ddr_ready = 1'b0;
                    drive_slot(rnd, 100, (i == nb - 1), acc);
                    if (acc) i++;
                    if (snap_v) begin
                        check_eq("stall_data", DDR_data_out, snap_d);
                        check_eq("stall_addr", DDR_addr_out, snap_a);
                    end else if (DDR_valid_out) begin
                        snap_v = 1'b1; snap_d = DDR_data_out; snap_a = DDR_addr_out;
                    end
                end
                check_eq("stall_ready_low", MAC_ready_out, 1'b0);
                stall_at = -1;
            end else begin
                ddr_ready = ($urandom_range(99) < ready_pct);
                drive_slot(rnd, valid_pct, (i == nb - 1), acc);
                if (acc) i++;
            end
            budget++;
        end
        mac_valid = 1'b0; mac_last = 1'b0;
        if (budget >= 3000) check_eq("send_timeout", 1'b1, 1'b0);
        budget = 0;
        while ((m_q.size() != 0 || m_valid || m_flush) && budget < 2000) begin
            ddr_ready = ($urandom_range(99) < ready_pct) || (ready_pct == 0);
            tick();
            budget++;
        end
        if (budget >= 2000) check_eq("drain_timeout", 1'b1, 1'b0);
        // Sink must see the sent byte stream, zero-padded to whole words
        nw = (sent.size() + 31) / 32;
        check_eq("word_count", cap_d.size(), nw);
        for (int k = 0; k < nw && k < cap_d.size(); k++) begin
            exp_w = '0;
            for (int j = 0; j < 32; j++)
                if (32*k + j < sent.size()) exp_w[j*8 +: 8] = sent[32*k + j];
            check_eq("stream_word", cap_d[k], exp_w);
            check_eq("stream_addr", cap_a[k], b_addr + 32'(32*k));
            check_eq("stream_last", cap_l[k], (k == nw - 1));
        end
    endtask

    logic [255:0] fw;
    int           pump;
    bit           acc_t;

    initial begin
        // Reset with random inputs
        #1 rstn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mac_valid = 1'($urandom); mac_last = 1'($urandom); ddr_ready = 1'($urandom);
            state_rst = 1'($urandom); base_addr = $urandom; gen_beat(1'b1);
            tick();
            check_eq("rst_ready", MAC_ready_out, 1'b0);
            check_eq("rst_valid", DDR_valid_out, 1'b0);
        end
        mac_valid = 1'b0; mac_last = 1'b0; state_rst = 1'b0; ddr_ready = 1'b1;
        #2 rstn = 1'b1;
        tick();
        check_eq("post_rst_ready", MAC_ready_out, 1'b1);

        // Continuous 16-beat tile
        send_tile(16, 1'b1, 32'h1000, 1'b0, 100, 100, -1);
        check_eq("cont_words", cap_d.size(), 9);
        for (int k = 0; k < 9 && k < cap_d.size(); k++) begin
            for (int j = 0; j < 32; j++) fw[j*8 +: 8] = 8'(32*k + j);
            check_eq("cont_data", cap_d[k], fw);
            check_eq("cont_addr", cap_a[k], 32'h1000 + 32'(32*k));
            check_eq("cont_last", cap_l[k], (k == 8));
        end

        // Partial tile of 54 bytes
        send_tile(3, 1'b1, 32'h2000, 1'b0, 100, 100, -1);
        check_eq("part_words", cap_d.size(), 2);
        if (cap_d.size() == 2) begin
            fw = '0;
            for (int j = 0; j < 22; j++) fw[j*8 +: 8] = 8'(32 + j);
            check_eq("part_w1", cap_d[1], fw);
            check_eq("part_last", cap_l[1], 1'b1);
        end

        // Backpressure during a stream
        send_tile(10, 1'b1, 32'h3000, 1'b0, 100, 100, 3);

        // state_rst with 20 residual bytes
        state_rst = 1'b1; base_addr = 32'h4000; tick(); state_rst = 1'b0;
        clear_caps();
        pump = 0;
        ddr_ready = 1'b1;
        while (m_q.size() != 20 && pump < 100) begin
            drive_slot(1'b0, 100, 1'b0, acc_t);
            pump++;
        end
        check_eq("cnt20_reached", m_q.size(), 20);
        mac_valid = 1'b0;
        state_rst = 1'b1; base_addr = 32'h8000;
        tick();
        state_rst = 1'b0;
        check_eq("srst_valid", DDR_valid_out, 1'b0);
        check_eq("srst_ready", MAC_ready_out, 1'b1);
        send_tile(2, 1'b0, 32'h8000, 1'b0, 100, 100, -1);
        if (cap_a.size() > 0) check_eq("srst_first_addr", cap_a[0], 32'h8000);

        // Async reset mid-stream
        state_rst = 1'b1; base_addr = 32'h5000; tick(); state_rst = 1'b0;
        for (int k = 0; k < 5; k++) drive_slot(1'b1, 100, 1'b0, acc_t);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_valid", DDR_valid_out, 1'b0);
        check_eq("arst_ready", MAC_ready_out, 1'b0);
        check_eq("arst_data", DDR_data_out, '0);
        check_eq("arst_addr", DDR_addr_out, '0);
        mac_valid = 1'b0;
        tick();
        #2 rstn = 1'b1;
        send_tile(2, 1'b0, 32'h0, 1'b0, 100, 100, -1);
        if (cap_d.size() == 2) begin
            fw = '0;
            for (int j = 0; j < 4; j++) fw[j*8 +: 8] = 8'(32 + j);
            check_eq("arst_w1", cap_d[1], fw);
        end

        // Random tiles
        for (int t = 0; t < 8; t++)
            send_tile($urandom_range(1, 20), 1'b1, $urandom, 1'b1,
                      $urandom_range(30, 100), $urandom_range(40, 100), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
